// File: rtl/conv_pkg.sv
// Shared types, widths and addressing helper for the conv2d engine.
package conv_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned TAP_W = 8;
  localparam int unsigned ACC_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte address of pixel (oy*sy+ky, ox*sx+kx) in the row-major image
  function automatic logic [31:0] pix_addr(
    input logic [7:0] oy,
    input logic [7:0] ox,
    input logic [3:0] ky,
    input logic [3:0] kx,
    input logic [3:0] sy,
    input logic [3:0] sx,
    input logic [7:0] dw
  );
    return (32'(oy) * 32'(sy) + 32'(ky)) * 32'(dw) + 32'(ox) * 32'(sx) + 32'(kx);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed 9x8 multiply-accumulate into a 32-bit wrapping accumulator.
module conv_mac
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [PIX_W-1:0]        i_pix,
  input  logic signed [TAP_W-1:0] i_tap,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int unsigned PROD_W = PIX_W + TAP_W + 1;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc;

  // Pixel is unsigned, so zero-extend before the signed multiply
  assign w_prod = PROD_W'($signed({1'b0, i_pix})) * PROD_W'(i_tap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/conv2d.sv
// Single-channel 2-D convolution engine with image and result memories.
// Optional build macro CONV_RELU_EN clamps negative results to zero on store.
module conv2d
  import conv_pkg::*;
#(
  parameter int unsigned DSIZE = 1024,
  parameter int unsigned KSIZE = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 data_width,
  input  logic [7:0]                 data_height,
  input  logic [7:0]                 result_width,
  input  logic [7:0]                 result_height,
  input  logic [3:0]                 stride_x,
  input  logic [3:0]                 stride_y,
  input  logic [8*KSIZE*KSIZE-1:0]   kernel,
  input  logic [3:0]                 kernel_width,
  input  logic [3:0]                 kernel_height,
  input  logic [$clog2(DSIZE):0]     mi_addr,
  input  logic [31:0]                mi_data,
  input  logic                       mi_wr,
  input  logic [$clog2(DSIZE):0]     mo_addr,
  output logic [31:0]                mo_data,
  input  logic                       start,
  output logic                       done
);

  localparam int unsigned AW     = $clog2(DSIZE);
  localparam int unsigned ADDR_W = AW + 1;
  localparam int unsigned RW     = AW - 2;
  localparam int unsigned RDEPTH = DSIZE / 4;
  localparam int unsigned NTAP   = KSIZE * KSIZE;
  localparam int unsigned TIW    = $clog2(NTAP);
  localparam logic [3:0]  K_MAX  = 4'(KSIZE);

  state_t r_state;
  logic   r_done;
  logic [7:0] r_ox, r_oy;
  logic [3:0] r_kx, r_ky;

  logic [PIX_W-1:0] r_img [DSIZE];
  logic [31:0]      r_res [RDEPTH];

  logic [3:0]  w_kw, w_kh, w_sx, w_sy;
  logic [31:0] w_paddr, w_ridx, w_res_val;
  logic [PIX_W-1:0] w_pix;
  logic signed [TAP_W-1:0] w_taps [NTAP];
  logic [TIW-1:0] w_tap_idx;
  logic signed [ACC_W-1:0] w_acc;
  logic w_idle, w_start_ok, w_img_we, w_res_we;
  logic w_last_kx, w_last_ky, w_last_ox, w_last_oy;
  logic w_unused;

  assign w_unused = ^{data_height, mi_addr[1:0]};

  // Degenerate configuration: size 0 -> 1, oversize -> KSIZE, stride 0 -> 1
  always_comb begin
    w_kw = kernel_width;
    w_kh = kernel_height;
    w_sx = (stride_x == 4'd0) ? 4'd1 : stride_x;
    w_sy = (stride_y == 4'd0) ? 4'd1 : stride_y;
    if (kernel_width == 4'd0)       w_kw = 4'd1;
    else if (kernel_width > K_MAX)  w_kw = K_MAX;
    if (kernel_height == 4'd0)      w_kh = 4'd1;
    else if (kernel_height > K_MAX) w_kh = K_MAX;
  end

  for (genvar g = 0; g < NTAP; g++) begin : g_tap
    assign w_taps[g] = kernel[g*8 +: 8];
  end

  assign w_tap_idx  = TIW'(32'(r_ky) * KSIZE + 32'(r_kx));
  assign w_paddr    = pix_addr(r_oy, r_ox, r_ky, r_kx, w_sy, w_sx, data_width);
  assign w_pix      = (w_paddr < 32'(DSIZE)) ? r_img[w_paddr[AW-1:0]] : '0;
  assign w_ridx     = 32'(r_oy) * (32'(result_width) + 32'd1) + 32'(r_ox);

  assign w_idle     = (r_state == IDLE) || (r_state == DONE);
  assign w_start_ok = w_idle && start;
  assign w_img_we   = w_idle && mi_wr && (mi_addr < ADDR_W'(DSIZE));
  assign w_res_we   = (r_state == STORE) && (w_ridx < 32'(RDEPTH));

  assign w_last_kx  = (r_kx == w_kw - 4'd1);
  assign w_last_ky  = (r_ky == w_kh - 4'd1);
  assign w_last_ox  = (r_ox == result_width);
  assign w_last_oy  = (r_oy == result_height);

`ifdef CONV_RELU_EN
  assign w_res_val  = w_acc[ACC_W-1] ? '0 : w_acc;
`else
  assign w_res_val  = w_acc;
`endif

  conv_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok || (r_state == STORE)),
    .i_en  (r_state == CALC),
    .i_pix (w_pix),
    .i_tap (w_taps[w_tap_idx]),
    .o_acc (w_acc)
  );

  // done trails entry into DONE by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_kx    <= '0;
      r_ky    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= CALC;
            r_done  <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_kx    <= '0;
            r_ky    <= '0;
          end else if (r_state == DONE) begin
            r_done  <= 1'b1;
          end
        end
        CALC: begin
          if (w_last_kx) begin
            r_kx <= '0;
            if (w_last_ky) begin
              r_ky    <= '0;
              r_state <= STORE;
            end else begin
              r_ky <= r_ky + 4'd1;
            end
          end else begin
            r_kx <= r_kx + 4'd1;
          end
        end
        STORE: begin
          r_state <= CALC;
          if (w_last_ox) begin
            r_ox <= '0;
            if (w_last_oy) begin
              r_oy    <= '0;
              r_state <= DONE;
            end else begin
              r_oy <= r_oy + 8'd1;
            end
          end else begin
            r_ox <= r_ox + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_img_we) begin
      r_img[{mi_addr[AW-1:2], 2'd0}] <= mi_data[7:0];
      r_img[{mi_addr[AW-1:2], 2'd1}] <= mi_data[15:8];
      r_img[{mi_addr[AW-1:2], 2'd2}] <= mi_data[23:16];
      r_img[{mi_addr[AW-1:2], 2'd3}] <= mi_data[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (w_res_we) begin
      r_res[w_ridx[RW-1:0]] <= w_res_val;
    end
  end

  assign mo_data = (mo_addr < ADDR_W'(RDEPTH)) ? r_res[mo_addr[RW-1:0]] : '0;
  assign done    = r_done;

endmodule

// File: tb/tb_conv2d.sv
// Self-checking bench for conv2d: directed plan scenarios plus randomized
// configurations checked against a loop-based convolution model.
module tb_conv2d;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_width, data_height, result_width, result_height;
  logic [3:0]  stride_x, stride_y, kernel_width, kernel_height;
  logic [71:0] kernel;
  logic [10:0] mi_addr, mo_addr;
  logic [31:0] mi_data, mo_data;
  logic        mi_wr, start, done;

  int n_cmp;
  int n_fail;

  logic [7:0]  img [1024];
  logic [31:0] exp_res [256];
  bit          exp_valid [256];
  logic [31:0] got [256];
  int          exp_lat;

  conv2d dut (
    .clk(clk), .rst_n(rst_n),
    .data_width(data_width), .data_height(data_height),
    .result_width(result_width), .result_height(result_height),
    .stride_x(stride_x), .stride_y(stride_y),
    .kernel(kernel), .kernel_width(kernel_width), .kernel_height(kernel_height),
    .mi_addr(mi_addr), .mi_data(mi_data), .mi_wr(mi_wr),
    .mo_addr(mo_addr), .mo_data(mo_data),
    .start(start), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: direct evaluation of the convolution sum for every output
  task automatic model_run();
    int kwe, khe, sxe, sye, acc, a, idx;
    logic [71:0] kk;
    logic signed [7:0] t [9];
    kwe = (kernel_width == 0) ? 1 : (kernel_width > 3) ? 3 : int'(kernel_width);
    khe = (kernel_height == 0) ? 1 : (kernel_height > 3) ? 3 : int'(kernel_height);
    sxe = (stride_x == 0) ? 1 : int'(stride_x);
    sye = (stride_y == 0) ? 1 : int'(stride_y);
    for (int i = 0; i < 9; i++) begin
      kk = kernel >> (8 * i);
      t[i] = kk[7:0];
    end
    for (int oy = 0; oy <= int'(result_height); oy++)
      for (int ox = 0; ox <= int'(result_width); ox++) begin
        acc = 0;
        for (int ky = 0; ky < khe; ky++)
          for (int kx = 0; kx < kwe; kx++) begin
            a = (oy * sye + ky) * int'(data_width) + ox * sxe + kx;
            if (a < 1024) acc += int'(t[ky * 3 + kx]) * int'(img[a]);
          end
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        idx = oy * (int'(result_width) + 1) + ox;
        if (idx < 256) begin
          exp_res[idx]   = acc;
          exp_valid[idx] = 1'b1;
        end
      end
    exp_lat = (int'(result_height) + 1) * (int'(result_width) + 1) * (khe * kwe + 1) + 1;
  endtask

  task automatic write_image();
    for (int w = 0; w < 256; w++) begin
      @(negedge clk);
      mi_wr   = 1'b1;
      mi_addr = 11'(w * 4);
      mi_data = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
    end
    @(negedge clk);
    mi_wr = 1'b0;
  endtask

  task automatic set_cfg(input int dw, input int rw, input int rh, input int sx,
                         input int sy, input int kw, input int kh, input logic [71:0] k);
    data_width    = 8'(dw);
    data_height   = 8'(dw);
    result_width  = 8'(rw);
    result_height = 8'(rh);
    stride_x      = 4'(sx);
    stride_y      = 4'(sy);
    kernel_width  = 4'(kw);
    kernel_height = 4'(kh);
    kernel        = k;
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int elapsed, output int lat);
    lat = -1;
    for (int c = elapsed + 1; c <= elapsed + 5000; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic read_results();
    for (int i = 0; i < 256; i++) begin
      mo_addr = 11'(i);
      #1 got[i] = mo_data;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done: got %b expected 0", done);
    end
  endtask

  task automatic test_1x1();
    int lat;
    for (int i = 0; i < 1024; i++) img[i] = 8'(i);
    write_image();
    set_cfg(8, 7, 7, 1, 1, 1, 1, 72'h2);
    model_run();
    start_run();
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 129) begin
      n_fail++;
      $display("FAIL 1x1_latency: got %0d expected 129", lat);
    end
    read_results();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== 32'(2 * i)) begin
        n_fail++;
        $display("FAIL 1x1_word[%0d]: got %0d expected %0d", i, got[i], 2 * i);
      end
    end
    for (int j = 0; j < 3; j++) begin
      mo_addr = (j == 0) ? 11'd256 : (j == 1) ? 11'd700 : 11'd2047;
      #1 n_cmp++;
      if (mo_data !== 32'd0) begin
        n_fail++;
        $display("FAIL mo_oob[%0d]: got %h expected 0", mo_addr, mo_data);
      end
    end
  endtask

  task automatic test_stride();
    int lat;
    set_cfg(8, 5, 2, 1, 2, 3, 3, {3{8'd1, 8'd0, 8'hFF}});
    model_run();
    start_run();
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 181) begin
      n_fail++;
      $display("FAIL stride_latency: got %0d expected 181", lat);
    end
    read_results();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL stride_word[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(exp_res[i]));
      end
    end
  endtask

  task automatic test_full();
    int lat;
    set_cfg(8, 5, 5, 1, 1, 3, 3, {3{8'd1, 8'd0, 8'hFF}});
    model_run();
    start_run();
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 361) begin
      n_fail++;
      $display("FAIL full_latency: got %0d expected 361", lat);
    end
    read_results();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== ((i < 36) ? 32'd6 : 32'(2 * i))) begin
        n_fail++;
        $display("FAIL full_word[%0d]: got %0d expected %0d", i, $signed(got[i]), (i < 36) ? 6 : 2 * i);
      end
    end
  endtask

  task automatic test_negative();
    int lat;
    logic [31:0] want;
`ifdef CONV_RELU_EN
    want = 32'd0;
`else
    want = 32'hFFFF_F709;
`endif
    for (int i = 0; i < 1024; i++) img[i] = 8'hFF;
    write_image();
    set_cfg(8, 5, 5, 1, 1, 3, 3, {9{8'hFF}});
    model_run();
    start_run();
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 361) begin
      n_fail++;
      $display("FAIL neg_latency: got %0d expected 361", lat);
    end
    read_results();
    for (int i = 0; i < 36; i++) begin
      n_cmp++;
      if (got[i] !== want || got[i] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL neg_word[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(want));
      end
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    for (int i = 0; i < 1024; i++) img[i] = 8'(i);
    write_image();
    set_cfg(8, 5, 5, 1, 1, 3, 3, {3{8'd1, 8'd0, 8'hFF}});
    model_run();
    start_run();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      mi_wr   = 1'b1;
      mi_addr = 11'd40;
      mi_data = 32'hFFFF_FFFF;
      start   = (c == 4);
      @(posedge clk);
      #1;
    end
    mi_wr = 1'b0;
    start = 1'b0;
    wait_done(12, lat);
    n_cmp++;
    if (lat !== 361) begin
      n_fail++;
      $display("FAIL busy_latency: got %0d expected 361", lat);
    end
    read_results();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL busy_word[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(exp_res[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    set_cfg(8, 5, 2, 1, 2, 3, 3, {3{8'd1, 8'd0, 8'hFF}});
    model_run();
    start_run();
    repeat (30) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_done: got %b expected 0", done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    start_run();
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 181) begin
      n_fail++;
      $display("FAIL rstmid_latency: got %0d expected 181", lat);
    end
    @(negedge clk) rst_n = 1'b0;
    #1 n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_done_drop: got %b expected 0", done);
    end
    @(negedge clk) rst_n = 1'b1;
    read_results();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL rst_retained[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(exp_res[i]));
      end
    end
  endtask

  task automatic test_random();
    int lat, dw, rw, rh, sx, sy;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
      write_image();
      @(negedge clk);
      mi_wr   = 1'b1;
      mi_addr = 11'(1024 + 4 * $urandom_range(0, 255));
      mi_data = $urandom;
      @(negedge clk);
      mi_wr = 1'b0;
      dw = (it == 0) ? 250 : int'($urandom_range(4, 24));
      sy = (it == 0) ? 3 : int'($urandom_range(0, 3));
      rh = (it == 0) ? 4 : int'($urandom_range(0, 5));
      rw = int'($urandom_range(0, 5));
      sx = int'($urandom_range(0, 3));
      set_cfg(dw, rw, rh, sx, sy, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              72'({$urandom, $urandom, $urandom}));
      model_run();
      start_run();
      wait_done(0, lat);
      n_cmp++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, exp_lat);
      end
      read_results();
      for (int i = 0; i < 256; i++) begin
        if (exp_valid[i]) begin
          n_cmp++;
          if (got[i] !== exp_res[i]) begin
            n_fail++;
            $display("FAIL rand%0d_word[%0d]: got %0d expected %0d", it, i, $signed(got[i]), $signed(exp_res[i]));
          end
        end
      end
    end
  endtask

  task automatic test_store_drop();
    int lat;
    for (int i = 0; i < 1024; i++) img[i] = 8'(i);
    write_image();
    set_cfg(21, 20, 15, 1, 1, 1, 1, 72'h1);
    model_run();
    start_run();
    wait_done(0, lat);
    n_cmp++;
    if (lat !== 673) begin
      n_fail++;
      $display("FAIL drop_latency: got %0d expected 673", lat);
    end
    read_results();
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (got[i] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL drop_word[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(exp_res[i]));
      end
    end
    mo_addr = 11'd256;
    #1 n_cmp++;
    if (mo_data !== 32'd0) begin
      n_fail++;
      $display("FAIL drop_oob: got %h expected 0", mo_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    start = 1'b0;
    mi_wr = 1'b0;
    mi_addr = '0;
    mi_data = '0;
    mo_addr = '0;
    for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;
    set_cfg(8, 0, 0, 1, 1, 1, 1, 72'h0);
    test_reset();
    test_1x1();
    test_stride();
    test_full();
    test_negative();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    test_store_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
